fec_bank_ctrl: RTL
==================

FEC_BANK_CTRL -- requirements
Module: fec_bank_ctrl

Interface
REQ-001 Parameter BLOCK_LEN, default 96: bits per FEC block and per bank.
REQ-002 Parameter ADDR_W, default 8: DPR address width; SHALL satisfy 2^ADDR_W >= 2*BLOCK_LEN.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset, named as in the codebase, with the ports below.
REQ-004 clock_50  input  1  sole clock; all state on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 in_valid  input  1  upstream bit valid.
REQ-007 in_ready  output  1  controller can accept a bit into the current write bank.
REQ-008 wr_en  output  1  DPR write strobe for port b.
REQ-009 wr_addr  output  ADDR_W  DPR port-b address.
REQ-010 seed_capture  output  1  qualifies the encoder tail-biting seed shift.
REQ-011 rd_req  input  1  encoder ready for the next bit.
REQ-012 rd_en  output  1  DPR read strobe for port a.
REQ-013 rd_addr  output  ADDR_W  DPR port-a address.
REQ-014 rd_valid  output  1  DPR q_a holds valid data this cycle.
REQ-015 blk_start  output  1  pulse with the read of bit 0 of a block.
REQ-016 blk_last  output  1  pulse with the read of bit BLOCK_LEN-1.
REQ-017 bank_full  output  2  per-bank full flag; bit b is bank b.

Function
REQ-018 Bank b SHALL occupy DPR addresses b*BLOCK_LEN to b*BLOCK_LEN+BLOCK_LEN-1.
REQ-019 in_ready SHALL equal !bank_full[wr_bank]; wr_en SHALL equal in_valid && in_ready, combinationally.
REQ-020 wr_addr SHALL equal wr_bank*BLOCK_LEN + wr_ofs.
REQ-021 On each accepted write, wr_ofs SHALL increment.
REQ-022 At wr_ofs == BLOCK_LEN-1, an accepted write SHALL clear wr_ofs to 0, set bank_full[wr_bank] and toggle wr_bank on the same edge.
REQ-023 seed_capture SHALL equal wr_en && wr_ofs >= BLOCK_LEN-6, i.e. the last 6 bits of each block.
REQ-024 The read FSM SHALL have states R_IDLE, R_RUN and R_DONE.
REQ-025 R_IDLE: if bank_full[rd_bank], go to R_RUN with rd_ofs = 0; otherwise stay.
REQ-026 R_RUN: rd_en = rd_req; rd_addr = rd_bank*BLOCK_LEN + rd_ofs; rd_ofs increments on each rd_en.
REQ-027 R_RUN: rd_en at rd_ofs == BLOCK_LEN-1 SHALL go to R_DONE.
REQ-028 rd_req low SHALL stall R_RUN with no address change.
REQ-029 R_DONE lasts one cycle: clear bank_full[rd_bank], toggle rd_bank, go to R_IDLE; rd_en SHALL be 0.
REQ-030 blk_start = rd_en && rd_ofs == 0; blk_last = rd_en && rd_ofs == BLOCK_LEN-1.
REQ-031 rd_valid SHALL be rd_en registered one cycle, matching the DPR read latency.
REQ-032 A set of one bank's flag (write side) and a clear of the other bank's flag (R_DONE) in the same cycle SHALL both take effect.
REQ-033 When both banks are full, in_ready SHALL be 0 and no wr_en is generated, so no bit is dropped.
REQ-034 Latency from the write completing a block to the first rd_en SHALL be 2 cycles when rd_req is high.

Reset
REQ-035 Reset assertion SHALL immediately force state R_IDLE, wr_bank = rd_bank = 0, wr_ofs = rd_ofs = 0, bank_full = 2'b00 and rd_valid = 0, even mid-block.
REQ-036 A partially written block SHALL be discarded by reset.
REQ-037 Immediately after reset, in_ready SHALL be 1 and all other outputs 0.

Configuration
REQ-038 With FEC_BANK_CTRL_STATS_EN defined, the block SHALL add output blk_count[15:0], incremented in R_DONE, wrapping 0xFFFF to 0, reset to 0.
REQ-039 With FEC_BANK_CTRL_STATS_EN defined, the block SHALL add output ovf_stall, a sticky bit set when in_valid && !in_ready, cleared only by reset.
REQ-040 Without FEC_BANK_CTRL_STATS_EN, neither port nor any of its logic SHALL exist.

Structure
REQ-041 Package fec_pkg SHALL hold BLOCK_LEN_DEF = 96, TAIL_LEN = 6 and enum rd_state_t {R_IDLE, R_RUN, R_DONE}.
REQ-042 Sub-module fec_addr_counter (bank bit, offset, wrap at BLOCK_LEN-1) SHALL be instantiated twice, once for write and once for read.

Verification
REQ-043 Reset, then 96 continuous writes -> wr_addr 0..95, seed_capture high for the writes at addresses 90..95, bank_full = 01, first rd_en at rd_addr 0 two cycles later.
REQ-044 rd_req held low while 192 bits are written -> bank_full = 11, in_ready = 0, and the 193rd in_valid is not accepted.
REQ-045 Full-rate streaming of 4 blocks -> rd_addr sequence 0..95, 96..191, 0..95, 96..191; blk_start at 0 and 96; blk_last at 95 and 191.
REQ-046 rd_req toggling every cycle -> rd_addr holds while stalled and rd_valid follows each rd_en by exactly 1 cycle.
REQ-047 Reset asserted at wr_ofs 40 during a read at rd_ofs 70 -> all outputs return to reset values asynchronously, and the next write goes to address 0.
REQ-048 With FEC_BANK_CTRL_STATS_EN, 3 blocks read -> blk_count = 3; forced overflow -> ovf_stall = 1 until reset.

Source files
------------

// File: rtl/fec_pkg.sv
// Shared constants and types for the FEC bank controller.
package fec_pkg;

    // Default bits per FEC block (and per DPR bank).
    localparam int BLOCK_LEN_DEF = 96;

    // Number of trailing block bits that seed the tail-biting encoder.
    localparam int TAIL_LEN = 6;

    // Read-side sequencing states.
    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_RUN  = 2'd1,
        R_DONE = 2'd2
    } rd_state_t;

endpackage

// File: rtl/fec_addr_counter.sv
// Bank/offset address counter for one side of the ping-pong DPR.
// The offset advances on inc and wraps to 0 after BLOCK_LEN-1; the bank bit
// toggles on bank_tgl. The output address is bank*BLOCK_LEN + offset.
module fec_addr_counter
    import fec_pkg::*;
#(
    parameter int BLOCK_LEN = BLOCK_LEN_DEF,
    parameter int ADDR_W    = 8,
    localparam int OFS_W    = (BLOCK_LEN > 1) ? $clog2(BLOCK_LEN) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              inc,
    input  logic              bank_tgl,
    output logic              bank,
    output logic [OFS_W-1:0]  ofs,
    output logic              at_last,
    output logic [ADDR_W-1:0] addr
);

    logic             bank_q, bank_d;
    logic [OFS_W-1:0] ofs_q, ofs_d;

    // Next offset/bank: wrap the offset at the end of a block, toggle bank on request.
    always_comb begin
        ofs_d   = ofs_q;
        bank_d  = bank_q ^ bank_tgl;
        at_last = (ofs_q == OFS_W'(BLOCK_LEN - 1));
        if (inc) begin
            if (at_last) begin
                ofs_d = '0;
            end else begin
                ofs_d = ofs_q + OFS_W'(1);
            end
        end
    end

    // Counter state; reset discards any partial progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ofs_q  <= '0;
            bank_q <= 1'b0;
        end else begin
            ofs_q  <= ofs_d;
            bank_q <= bank_d;
        end
    end

    // Map bank/offset onto the flat DPR address space.
    always_comb begin
        bank = bank_q;
        ofs  = ofs_q;
        addr = bank_q ? (ADDR_W'(BLOCK_LEN) + ADDR_W'(ofs_q)) : ADDR_W'(ofs_q);
    end

endmodule

// File: rtl/fec_bank_ctrl.sv
// Ping-pong bank controller for the FEC block buffer.
// Upstream bits are written into one DPR bank while the encoder reads the
// other; a bank is handed over when full and released after its last read.
// Optional build macro FEC_BANK_CTRL_STATS_EN adds blk_count and ovf_stall.
module fec_bank_ctrl
    import fec_pkg::*;
#(
    parameter int BLOCK_LEN = BLOCK_LEN_DEF,
    parameter int ADDR_W    = 8
) (
    input  logic              clock_50,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic              seed_capture,
    input  logic              rd_req,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              rd_valid,
    output logic              blk_start,
    output logic              blk_last,
    output logic [1:0]        bank_full
`ifdef FEC_BANK_CTRL_STATS_EN
    ,
    output logic [15:0]       blk_count,
    output logic              ovf_stall
`endif
);

    localparam int OFS_W = (BLOCK_LEN > 1) ? $clog2(BLOCK_LEN) : 1;

    logic             wr_bank, rd_bank;
    logic [OFS_W-1:0] wr_ofs, rd_ofs;
    logic             wr_at_last, rd_at_last;
    logic             wr_wrap;
    logic             rd_done;

    logic [1:0]       bank_full_q, bank_full_d;
    rd_state_t        state_q, state_d;
    logic             rd_valid_q, rd_valid_d;

    fec_addr_counter #(
        .BLOCK_LEN (BLOCK_LEN),
        .ADDR_W    (ADDR_W)
    ) u_wr_cnt (
        .clk      (clock_50),
        .rst_n    (reset),
        .inc      (wr_en),
        .bank_tgl (wr_wrap),
        .bank     (wr_bank),
        .ofs      (wr_ofs),
        .at_last  (wr_at_last),
        .addr     (wr_addr)
    );

    fec_addr_counter #(
        .BLOCK_LEN (BLOCK_LEN),
        .ADDR_W    (ADDR_W)
    ) u_rd_cnt (
        .clk      (clock_50),
        .rst_n    (reset),
        .inc      (rd_en),
        .bank_tgl (rd_done),
        .bank     (rd_bank),
        .ofs      (rd_ofs),
        .at_last  (rd_at_last),
        .addr     (rd_addr)
    );

    // Write side: accept only into a non-full bank; the final TAIL_LEN bits seed the encoder.
    always_comb begin
        in_ready     = !bank_full_q[wr_bank];
        wr_en        = in_valid && in_ready;
        wr_wrap      = wr_en && wr_at_last;
        seed_capture = wr_en && (wr_ofs >= OFS_W'(BLOCK_LEN - TAIL_LEN));
    end

    // Read FSM next state and strobes: wait for a full bank, stream it, release it.
    always_comb begin
        state_d = state_q;
        rd_en   = 1'b0;
        rd_done = 1'b0;
        case (state_q)
            R_IDLE: begin
                if (bank_full_q[rd_bank]) begin
                    state_d = R_RUN;
                end
            end
            R_RUN: begin
                rd_en = rd_req;
                if (rd_req && rd_at_last) begin
                    state_d = R_DONE;
                end
            end
            R_DONE: begin
                rd_done = 1'b1;
                state_d = R_IDLE;
            end
            default: begin
                state_d = R_IDLE;
            end
        endcase
        blk_start  = rd_en && (rd_ofs == '0);
        blk_last   = rd_en && rd_at_last;
        rd_valid_d = rd_en;
    end

    // Bank flags: a release and a fill of the opposite bank can land on the same edge.
    always_comb begin
        bank_full_d = bank_full_q;
        if (rd_done) begin
            bank_full_d[rd_bank] = 1'b0;
        end
        if (wr_wrap) begin
            bank_full_d[wr_bank] = 1'b1;
        end
    end

    // Control state registers; rd_valid tracks the one-cycle DPR read latency.
    always_ff @(posedge clock_50 or negedge reset) begin
        if (!reset) begin
            state_q     <= R_IDLE;
            bank_full_q <= 2'b00;
            rd_valid_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            bank_full_q <= bank_full_d;
            rd_valid_q  <= rd_valid_d;
        end
    end

    assign rd_valid  = rd_valid_q;
    assign bank_full = bank_full_q;

`ifdef FEC_BANK_CTRL_STATS_EN
    logic [15:0] blk_count_q, blk_count_d;
    logic        ovf_stall_q, ovf_stall_d;

    // Statistics: count released blocks (wrapping) and latch any refused upstream bit.
    always_comb begin
        blk_count_d = blk_count_q + {15'd0, rd_done};
        ovf_stall_d = ovf_stall_q | (in_valid && !in_ready);
    end

    // Statistics registers, cleared only by reset.
    always_ff @(posedge clock_50 or negedge reset) begin
        if (!reset) begin
            blk_count_q <= 16'd0;
            ovf_stall_q <= 1'b0;
        end else begin
            blk_count_q <= blk_count_d;
            ovf_stall_q <= ovf_stall_d;
        end
    end

    assign blk_count = blk_count_q;
    assign ovf_stall = ovf_stall_q;
`endif

endmodule
